// File: rtl/axis_cmp_pkg.sv
// Shared types and default widths for the AXI4-Stream compare controller.
package axis_cmp_pkg;

  localparam int DFLT_DATA_W = 32;
  localparam int DFLT_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  // Bits needed to hold the value t; never less than one bit.
  function automatic int timer_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/axis_idle_timer.sv
// Down-counter that flags a run as stalled after TIMEOUT consecutive counted
// cycles. A clear reloads the full budget; TIMEOUT of 0 disables expiry.
module axis_idle_timer
  import axis_cmp_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{i_clk, i_resetn, i_clear, i_count};
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam int W = timer_width(TIMEOUT);
      localparam logic [W-1:0] LOAD = W'(TIMEOUT);

      logic [W-1:0] r_remaining;

      // Reload on clear, otherwise burn one unit of budget per counted cycle.
      always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
          r_remaining <= LOAD;
        end else if (i_clear) begin
          r_remaining <= LOAD;
        end else if (i_count && (r_remaining != '0)) begin
          r_remaining <= r_remaining - W'(1);
        end
      end

      // Expire in the cycle whose count uses up the last unit of budget.
      assign o_expire = i_count && (r_remaining == W'(1));
    end
  endgenerate

endmodule

// File: rtl/axis_compare_ctrl.sv
// Run-level sequencer comparing two AXI4-Stream sources beat by beat.
// A start command arms a run of beat_count pairs; each pair is consumed only
// when both streams are valid together. The run ends with a pass/fail verdict,
// a saturating mismatch count and a capture of the first mismatching pair, or
// with a timeout if neither stream pairs up for too long.
module axis_compare_ctrl
  import axis_cmp_pkg::*;
#(
  parameter int DATA_W         = DFLT_DATA_W,
  parameter int CNT_W          = DFLT_CNT_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_beat_count,
  input  logic              i_in1_valid,
  output logic              o_in1_ready,
  input  logic [DATA_W-1:0] i_in1_data,
  input  logic              i_in2_valid,
  output logic              o_in2_ready,
  input  logic [DATA_W-1:0] i_in2_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_mismatch_count,
  output logic [CNT_W-1:0]  o_first_idx,
  output logic [DATA_W-1:0] o_first_a,
  output logic [DATA_W-1:0] o_first_b
);

  cmp_state_e        r_state;
  cmp_state_e        w_next_state;
  logic [CNT_W-1:0]  r_beat_count;
  logic [CNT_W-1:0]  r_beat_idx;
  logic [CNT_W-1:0]  r_mismatch_count;
  logic [CNT_W-1:0]  r_first_idx;
  logic [DATA_W-1:0] r_first_a;
  logic [DATA_W-1:0] r_first_b;
  logic              r_timeout;

  logic w_fire;
  logic w_last;
  logic w_accept;
  logic w_data_diff;
  logic w_timer_clear;
  logic w_timer_count;
  logic w_expire;

  // A pair transfers only when both sources offer a beat during a run; ready
  // is held low while reset is asserted so nothing is consumed mid-reset.
  assign w_fire        = (r_state == ST_RUN) && i_in1_valid && i_in2_valid && i_resetn;
  assign w_last        = w_fire && (r_beat_idx == (r_beat_count - CNT_W'(1)));
  assign w_accept      = i_start && (r_state != ST_RUN);
  assign w_data_diff   = (i_in1_data != i_in2_data);
  assign w_timer_clear = w_accept || w_fire;
  assign w_timer_count = (r_state == ST_RUN) && !w_fire;

  assign o_in1_ready = w_fire;
  assign o_in2_ready = w_fire;

  axis_idle_timer #(
    .TIMEOUT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_clear  (w_timer_clear),
    .i_count  (w_timer_count),
    .o_expire (w_expire)
  );

  // Next-state selection: start is honoured only outside a run, and a run
  // ends on its final pair or when the idle timer runs out.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_next_state = (i_beat_count != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_last || w_expire) begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, beat bookkeeping and result capture. A fresh start wipes the
  // previous run; the first mismatch is the one seen while the count is zero.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state          <= ST_IDLE;
      r_beat_count     <= '0;
      r_beat_idx       <= '0;
      r_mismatch_count <= '0;
      r_first_idx      <= '0;
      r_first_a        <= '0;
      r_first_b        <= '0;
      r_timeout        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_beat_count     <= i_beat_count;
        r_beat_idx       <= '0;
        r_mismatch_count <= '0;
        r_first_idx      <= '0;
        r_first_a        <= '0;
        r_first_b        <= '0;
        r_timeout        <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (w_fire) begin
          r_beat_idx <= r_beat_idx + CNT_W'(1);
          if (w_data_diff) begin
            if (r_mismatch_count != '1) begin
              r_mismatch_count <= r_mismatch_count + CNT_W'(1);
            end
            if (r_mismatch_count == '0) begin
              r_first_idx <= r_beat_idx;
              r_first_a   <= i_in1_data;
              r_first_b   <= i_in2_data;
            end
          end
        end else if (w_expire) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // Status decode straight from registered state; pass only means anything
  // once the run has finished.
  assign o_busy           = (r_state == ST_RUN);
  assign o_done           = (r_state == ST_DONE);
  assign o_pass           = o_done && (r_mismatch_count == '0) && !r_timeout;
  assign o_timeout        = r_timeout;
  assign o_mismatch_count = r_mismatch_count;
  assign o_first_idx      = r_first_idx;
  assign o_first_a        = r_first_a;
  assign o_first_b        = r_first_b;

endmodule

// File: tb/tb_axis_compare_ctrl.sv
// Scoreboard bench for axis_compare_ctrl: stimulus pushes the verdict a run
// should produce, and an independent monitor checks handshakes every cycle
// and pops/compares the verdict when a run finishes.
module tb_axis_compare_ctrl;
  import axis_cmp_pkg::*;

  localparam int DW       = DFLT_DATA_W;
  localparam int CW       = DFLT_CNT_W;
  localparam int TMO      = 8;
  localparam int NO_STALL = 1 << 20;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [CW-1:0] beatCount;
  logic          aValid, aReady, bValid, bReady;
  logic [DW-1:0] aData, bData;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] mismatchCount, firstIdx;
  logic [DW-1:0] firstA, firstB;

  always #5 clk = ~clk;

  axis_compare_ctrl #(
    .DATA_W         (DW),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk            (clk),
    .i_resetn         (resetn),
    .i_start          (start),
    .i_beat_count     (beatCount),
    .i_in1_valid      (aValid),
    .o_in1_ready      (aReady),
    .i_in1_data       (aData),
    .i_in2_valid      (bValid),
    .o_in2_ready      (bReady),
    .i_in2_data       (bData),
    .o_busy           (busy),
    .o_done           (done),
    .o_pass           (pass),
    .o_timeout        (timeout),
    .o_mismatch_count (mismatchCount),
    .o_first_idx      (firstIdx),
    .o_first_a        (firstA),
    .o_first_b        (firstB)
  );

  typedef struct packed {
    int            pairs;
    logic [CW-1:0] mm;
    logic [CW-1:0] fidx;
    logic [DW-1:0] fa;
    logic [DW-1:0] fb;
    logic          pass;
    logic          tmo;
    int            delta;
    int            total;
  } exp_t;

  exp_t          expQ[$];
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            errors = 0;
  int            checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Verdict of a run worked out from the beat lists: the pairs that can form,
  // how many differ, which differs first, and when done should appear.
  function automatic exp_t modelRun(input int n, input int stallA, input bit noGaps);
    exp_t e;
    int   k;
    bit   seen;
    e    = '0;
    seen = 1'b0;
    k    = (stallA < n) ? stallA : n;
    e.pairs = k;
    for (int i = 0; i < k; i++) begin
      if (qa[i] != qb[i]) begin
        if (!seen) begin
          seen   = 1'b1;
          e.fidx = CW'(i);
          e.fa   = qa[i];
          e.fb   = qb[i];
        end
        if (e.mm != {CW{1'b1}}) e.mm = e.mm + 1'b1;
      end
    end
    e.tmo   = (stallA < n);
    e.pass  = (e.mm == '0) && !e.tmo;
    e.delta = e.tmo ? TMO + 1 : 1;
    if (n == 0) e.total = 1;
    else if (noGaps && !e.tmo) e.total = n + 1;
    else e.total = -1;
    return e;
  endfunction

  task automatic fillRandom(input int n, input bit allowDiff);
    logic [DW-1:0] a;
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      qa.push_back(a);
      if (allowDiff && ($urandom_range(2, 0) == 0)) qb.push_back(a ^ ($urandom | 32'h1));
      else qb.push_back(a);
    end
  endtask

  // Monitor: handshake legality every cycle, verdict when a run completes.
  int   cyc = 0;
  int   anchor = 0;
  int   startCyc = 0;
  int   firesSeen = 0;
  bit   pending = 1'b0;
  exp_t monExp;

  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      checkOutput("ready_legal", aReady, busy && aValid && bValid);
      checkOutput("ready_pair", bReady, aReady);
      if (!done) checkOutput("pass_outside_done", pass, 1'b0);
      if (aReady) begin
        firesSeen++;
        anchor = cyc;
      end
      if (pending && done) begin
        pending = 1'b0;
        checkOutput("verdict_expected", expQ.size() > 0, 1'b1);
        if (expQ.size() > 0) begin
          monExp = expQ.pop_front();
          checkOutput("pairs", firesSeen, monExp.pairs);
          checkOutput("mismatch_count", mismatchCount, monExp.mm);
          checkOutput("first_idx", firstIdx, monExp.fidx);
          checkOutput("first_a", firstA, monExp.fa);
          checkOutput("first_b", firstB, monExp.fb);
          checkOutput("pass", pass, monExp.pass);
          checkOutput("timeout", timeout, monExp.tmo);
          checkOutput("busy_at_done", busy, 1'b0);
          checkOutput("done_delay", cyc - anchor, monExp.delta);
          if (monExp.total >= 0) checkOutput("start_to_done", cyc - startCyc, monExp.total);
        end
      end
      if (start && !busy) begin
        pending   = 1'b1;
        anchor    = cyc;
        startCyc  = cyc;
        firesSeen = 0;
      end
    end
  end

  // One run: start, then two independent producers with random idle gaps.
  // stallA stops stream A after that many beats; pulseAt injects a start
  // during the run; resetAfter pulses reset once that many pairs have fired.
  task automatic applyStimulus(input int n, input int aLo, input int aHi, input int bLo, input int bHi,
                               input int stallA, input int pulseAt, input int resetAfter);
    int idxA = 0;
    int idxB = 0;
    int gapA, gapB;
    bit fA, fB;
    bit seenDone = 1'b0;
    bit aborted = 1'b0;
    if (resetAfter < 0) expQ.push_back(modelRun(n, stallA, (aHi == 0) && (bHi == 0)));
    @(posedge clk); #1;
    start     = 1'b1;
    beatCount = CW'(n);
    @(posedge clk); #1;
    start     = 1'b0;
    beatCount = CW'($urandom);
    gapA = $urandom_range(aHi, aLo);
    gapB = $urandom_range(bHi, bLo);
    for (int c = 0; c < 400; c++) begin
      aValid = (idxA < n) && (idxA < stallA) && (gapA == 0);
      aData  = (idxA < n) ? qa[idxA] : DW'($urandom);
      bValid = (idxB < n) && (gapB == 0);
      bData  = (idxB < n) ? qb[idxB] : DW'($urandom);
      if (c == pulseAt) begin
        start     = 1'b1;
        beatCount = CW'(n + 3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      fA = aValid && aReady;
      fB = bValid && bReady;
      seenDone = done;
      @(posedge clk); #1;
      if (fA) gapA = $urandom_range(aHi, aLo);
      else if (!aValid && gapA > 0) gapA--;
      if (fB) gapB = $urandom_range(bHi, bLo);
      else if (!bValid && gapB > 0) gapB--;
      if (fA) idxA++;
      if (fB) idxB++;
      if (resetAfter >= 0 && idxA == resetAfter && idxB == resetAfter) begin
        start  = 1'b0;
        aValid = 1'b0;
        bValid = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        aValid = 1'b1;
        bValid = 1'b1;
        aData  = qa[idxA];
        bData  = qb[idxB];
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_pass", pass, 1'b0);
        checkOutput("rst_timeout", timeout, 1'b0);
        checkOutput("rst_mismatch_count", mismatchCount, '0);
        checkOutput("rst_first_idx", firstIdx, '0);
        checkOutput("rst_first_a", firstA, '0);
        checkOutput("rst_first_b", firstB, '0);
        checkOutput("rst_ready", aReady, 1'b0);
        aborted = 1'b1;
        break;
      end
      if (seenDone) break;
    end
    start = 1'b0;
    checkOutput("run_finished", seenDone || aborted, 1'b1);
    if (!(seenDone || aborted)) expQ.delete();
    // Offer beats on both streams after the run: nothing may be taken.
    aValid = 1'b1;
    bValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    aValid = 1'b0;
    bValid = 1'b0;
    checkOutput("verdict_consumed", expQ.size(), 0);
    expQ.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    beatCount = '0;
    aValid    = 1'b1;
    bValid    = 1'b1;
    aData     = '0;
    bData     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_pass", pass, 1'b0);
    checkOutput("reset_timeout", timeout, 1'b0);
    checkOutput("reset_mismatch_count", mismatchCount, '0);
    checkOutput("reset_first_idx", firstIdx, '0);
    checkOutput("reset_first_a", firstA, '0);
    checkOutput("reset_first_b", firstB, '0);
    checkOutput("reset_ready", aReady || bReady, 1'b0);
    aValid = 1'b0;
    bValid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    qa = '{32'd1, 32'd2, 32'd3, 32'd4};
    qb = '{32'd1, 32'd2, 32'd3, 32'd4};
    applyStimulus(4, 0, 0, 0, 0, NO_STALL, -1, -1);

    qa = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    qb = '{32'd1, 32'd2, 32'd9, 32'd4, 32'd7};
    applyStimulus(5, 0, 0, 0, 0, NO_STALL, -1, -1);

    fillRandom(3, 1'b0);
    applyStimulus(3, 0, 0, 1, 1, NO_STALL, -1, -1);

    fillRandom(4, 1'b1);
    applyStimulus(4, 0, 0, 0, 0, 1, -1, -1);

    qa.delete();
    qb.delete();
    applyStimulus(0, 0, 0, 0, 0, NO_STALL, -1, -1);

    fillRandom(6, 1'b1);
    applyStimulus(6, 0, 1, 0, 1, NO_STALL, 2, -1);

    fillRandom(6, 1'b1);
    qb[0] = qa[0] ^ 32'h1;
    applyStimulus(6, 0, 0, 0, 0, NO_STALL, -1, 2);

    fillRandom(6, 1'b1);
    applyStimulus(6, 0, 0, 0, 0, NO_STALL, -1, -1);

    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(20, 1);
      fillRandom(n, 1'b1);
      applyStimulus(n, 0, 2, 0, 2, NO_STALL, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
